// File: rtl/ssd_display_driver_pkg.sv
// ssd_display_driver_pkg
//   Shared definitions for the seven-segment display driver:
//   data width, conversion FSM states, active-low segment patterns
//   ({g,f,e,d,c,b,a}) and the double-dabble nibble adjust helper.
package ssd_display_driver_pkg;

    localparam int SSD_DATA_W = 13;

    typedef enum logic [1:0] {
        SSD_IDLE = 2'd0,
        SSD_CONV = 2'd1,
        SSD_DONE = 2'd2
    } ssd_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Each nibble >= 5 gets +3 independently; no carry crosses a nibble
    // boundary because an adjusted nibble never exceeds 4'hC.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int k = 0; k < 4; k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ssd_display_driver_bcd_to_7seg.sv
// bcd_to_7seg
//   Combinational BCD digit to active-low seven-segment decoder.
//   Ports:
//     bcd  in  4  BCD digit; values above 9 decode to all segments off
//     seg  out 7  active-low cathodes {g,f,e,d,c,b,a}
module bcd_to_7seg
    import ssd_display_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_display_driver.sv
// ssd_display_driver
//   Converts a 13-bit unsigned value to four BCD digits with a sequential
//   double-dabble engine and time-multiplexes them onto a 4-digit,
//   active-low, common-anode seven-segment display.
//   Ports:
//     clk        in   1   system clock
//     reset      in   1   synchronous, active-high reset
//     value      in   13  value to display (0..8191)
//     an         out  4   digit anodes, active-low, registered; an[0] rightmost
//     seg        out  7   cathodes {g,f,e,d,c,b,a}, active-low, registered
//     dp         out  1   decimal point, always off (1)
//     bcd        out  16  displayed BCD {d3,d2,d1,d0}, registered
//     busy       out  1   conversion in progress
//     bcd_valid  out  1   first conversion after reset has completed
module ssd_display_driver
    import ssd_display_driver_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SSD_DATA_W-1:0] value,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [15:0]           bcd,
    output logic                  busy,
    output logic                  bcd_valid
);

    ssd_state_e             state_q, state_d;
    logic [SSD_DATA_W-1:0]  shreg_q, shreg_d;
    logic [SSD_DATA_W-1:0]  cap_q, cap_d;
    logic [SSD_DATA_W-1:0]  last_value_q, last_value_d;
    logic [15:0]            scratch_q, scratch_d;
    logic [3:0]             it_q, it_d;
    logic                   force_q, force_d;
    logic [15:0]            bcd_q, bcd_d;
    logic                   bcd_valid_q, bcd_valid_d;
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]             an_q, an_d;
    logic [6:0]             seg_q, seg_d;

    logic [15:0]            adj;
    logic [1:0]             sel;
    logic [3:0]             nibble;
    logic                   lz_blank;
    logic                   lit;
    logic [6:0]             seg_dec;

    bcd_to_7seg u_dec (
        .bcd (nibble),
        .seg (seg_dec)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cap_d        = cap_q;
        last_value_d = last_value_q;
        scratch_d    = scratch_q;
        it_d         = it_q;
        force_d      = force_q;
        bcd_d        = bcd_q;
        bcd_valid_d  = bcd_valid_q;
        adj          = dabble_adjust(scratch_q);

        case (state_q)
            SSD_IDLE: begin
                if ((value != last_value_q) || force_q) begin
                    shreg_d   = value;
                    cap_d     = value;
                    scratch_d = 16'h0000;
                    it_d      = 4'd0;
                    force_d   = 1'b0;
                    state_d   = SSD_CONV;
                end
            end
            SSD_CONV: begin
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                it_d = it_q + 4'd1;
                if (it_q == 4'd12) begin
                    state_d = SSD_DONE;
                end
            end
            SSD_DONE: begin
                bcd_d        = scratch_q;
                last_value_d = cap_q;
                bcd_valid_d  = 1'b1;
                state_d      = SSD_IDLE;
            end
            default: state_d = SSD_IDLE;
        endcase
    end

    // Scan path works from registered bcd, so the digits follow bcd by one edge.
    always_comb begin
        cnt_d    = cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        sel      = cnt_q[REFRESH_BITS-1 -: 2];
        nibble   = bcd_q[3:0];
        lz_blank = 1'b0;
        case (sel)
            2'd0: begin nibble = bcd_q[3:0];   lz_blank = 1'b0;                  end
            2'd1: begin nibble = bcd_q[7:4];   lz_blank = (bcd_q[15:4]  == '0);  end
            2'd2: begin nibble = bcd_q[11:8];  lz_blank = (bcd_q[15:8]  == '0);  end
            default: begin nibble = bcd_q[15:12]; lz_blank = (bcd_q[15:12] == '0); end
        endcase
        lit   = bcd_valid_q && !(BLANK_LZ && lz_blank);
        an_d  = lit ? ~(4'b0001 << sel) : 4'b1111;
        seg_d = lit ? seg_dec : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SSD_IDLE;
            shreg_q      <= '0;
            cap_q        <= '0;
            last_value_q <= '0;
            scratch_q    <= '0;
            it_q         <= '0;
            force_q      <= 1'b1;
            bcd_q        <= '0;
            bcd_valid_q  <= 1'b0;
            cnt_q        <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cap_q        <= cap_d;
            last_value_q <= last_value_d;
            scratch_q    <= scratch_d;
            it_q         <= it_d;
            force_q      <= force_d;
            bcd_q        <= bcd_d;
            bcd_valid_q  <= bcd_valid_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;
    assign bcd       = bcd_q;
    assign busy      = (state_q != SSD_IDLE);
    assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
module tb_ssd_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd;
    logic        busy;
    logic        bcd_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111;

    ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .bcd       (bcd),
        .busy      (busy),
        .bcd_valid (bcd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"},    {28'd0, an},         32'hF);
        check({tag, "_seg"},   {25'd0, seg},        32'h7F);
        check({tag, "_dp"},    {31'd0, dp},         32'h1);
        check({tag, "_bcd"},   {16'd0, bcd},        32'h0);
        check({tag, "_busy"},  {31'd0, busy},       32'h0);
        check({tag, "_valid"}, {31'd0, bcd_valid},  32'h0);
    endtask

    // Counts busy cycles of one conversion, ending at the first idle sample after it.
    task automatic measure_busy(output int n, output logic to);
        n  = 0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Slot i expected at an_e[4*i+:4], seg_e[7*i+:7]; 4 cycles per slot.
    task automatic check_scan(input string tag, input logic [15:0] an_e,
                              input logic [27:0] seg_e, input int rounds);
        logic [3:0] prev;
        logic       found;
        bit         first;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an === 4'b1110 && prev !== 4'b1110) begin
                found = 1'b1;
                break;
            end
            prev = an;
        end
        check({tag, "_sync_timeout"}, {31'd0, found}, 32'h1);
        if (!found) return;
        first = 1'b1;
        for (int r = 0; r < rounds; r++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    if (!first) @(negedge clk);
                    first = 1'b0;
                    check({tag, "_an"},  {28'd0, an},  {28'd0, an_e[4*s +: 4]});
                    check({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_e[7*s +: 7]});
                    check({tag, "_dp"},  {31'd0, dp},  32'h1);
                end
            end
        end
    endtask

    initial begin
        int          n;
        logic        to;
        int          rises;
        int          idle_gap;
        logic        prev_busy;
        logic        fell;
        logic [15:0] first_bcd;

        // 1. reset and forced conversion of 0
        reset = 1'b1;
        value = 13'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("t1_reset");
        reset = 1'b0;
        measure_busy(n, to);
        check("t1_timeout",  {31'd0, to},        32'h0);
        check("t1_busy_len", n,                  32'd14);
        check("t1_bcd",      {16'd0, bcd},       32'h0000);
        check("t1_valid",    {31'd0, bcd_valid}, 32'h1);
        check_scan("t1_scan", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                   {PB, PB, PB, P0}, 1);

        // 2. full-scale value
        value = 13'd8191;
        measure_busy(n, to);
        check("t2_timeout",  {31'd0, to},  32'h0);
        check("t2_busy_len", n,            32'd14);
        check("t2_bcd",      {16'd0, bcd}, 32'h8191);
        check_scan("t2_scan", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {P8, P1, P9, P1}, 1);

        // 3. change during conversion is picked up after one idle cycle
        value     = 13'd1234;
        rises     = 0;
        idle_gap  = 0;
        prev_busy = 1'b0;
        fell      = 1'b0;
        first_bcd = 16'hFFFF;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            if (!busy && prev_busy) begin
                fell = 1'b1;
                if (rises == 1) first_bcd = bcd;
            end
            if (!busy && rises == 1 && fell) idle_gap++;
            prev_busy = busy;
            if (i == 6) value = 13'd42;
        end
        check("t3_rises",     rises,             32'd2);
        check("t3_first_bcd", {16'd0, first_bcd}, 32'h1234);
        check("t3_idle_gap",  idle_gap,          32'd1);
        check("t3_final_bcd", {16'd0, bcd},      32'h0042);
        check_scan("t3_scan", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                   {PB, PB, P4, P2}, 1);

        // 4. steady value converts exactly once; interior zero shown
        value     = 13'd100;
        rises     = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check("t4_rises", rises,        32'd1);
        check("t4_bcd",   {16'd0, bcd}, 32'h0100);
        check_scan("t4_scan", {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                   {PB, P1, P0, P0}, 1);

        // 5. reset mid-conversion, then forced re-conversion
        value = 13'd5555;
        repeat (7) @(negedge clk);
        check("t5_busy_mid", {31'd0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t5_reset");
        reset = 1'b0;
        measure_busy(n, to);
        check("t5_timeout",  {31'd0, to},        32'h0);
        check("t5_busy_len", n,                  32'd14);
        check("t5_bcd",      {16'd0, bcd},       32'h5555);
        check("t5_valid",    {31'd0, bcd_valid}, 32'h1);

        // 6. scan counter wraps cleanly over several rounds
        check_scan("t6_scan", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {P5, P5, P5, P5}, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
